// File: rtl/filter_pkg.sv
// Shared constants for the binary median filter: image geometry, the valid
// output region it produces, and the readout state encoding.
package filter_pkg;

  localparam int IMAGE_WIDTH  = 240;
  localparam int IMAGE_HEIGHT = 180;
  localparam int WINDOW_SIZE  = 3;
  localparam int OUT_WIDTH    = IMAGE_WIDTH - WINDOW_SIZE + 1;
  localparam int OUT_HEIGHT   = IMAGE_HEIGHT - WINDOW_SIZE + 1;

  localparam logic [1:0] READER_IDLE  = 2'd0;
  localparam logic [1:0] READER_READ  = 2'd1;
  localparam logic [1:0] READER_DRAIN = 2'd2;

  // Places one pixel bit into the byte being assembled.
  function automatic logic [7:0] insertBit(logic [7:0] acc, logic bitVal, logic [2:0] idx);
    return acc | (8'(bitVal) << idx);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small FIFO of {last, byte} entries; push and pop in the same cycle are both
// honoured even when full. DEPTH must be a power of two.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && (count != '0);
  assign doPush = push && ((count != CNT_W'(DEPTH)) || doPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/filtered_frame_reader.sv
// Drains the filtered frame RAM in row-major order, packs 8 pixels per byte
// (LSB first, no row padding) and streams bytes over valid/ready.
module filtered_frame_reader #(
  parameter int OUT_WIDTH  = filter_pkg::OUT_WIDTH,
  parameter int OUT_HEIGHT = filter_pkg::OUT_HEIGHT,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              readerReady,
  output logic [ADDR_W-1:0] xReadAddress,
  output logic [ADDR_W-1:0] yReadAddress,
  output logic              readEnable,
  input  logic              readData,
  output logic [7:0]        byteOut,
  output logic              byteValid,
  input  logic              byteReady,
  output logic              lastByte,
  output logic              readerDone
);
  import filter_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] xAddr;
  logic [ADDR_W-1:0] yAddr;
  logic              atLastCol;
  logic              atLastRow;
  logic              lastIssue;
  logic [CNT_W-1:0]  fifoCount;
  logic              readVld_p1;
  logic              lastPix_p1;
  logic [7:0]        packReg_p1;
  logic [2:0]        bitIdx_p1;
  logic [7:0]        packedByte;
  logic              pushByte;
  logic              popByte;
  logic [8:0]        fifoHead;

  assign readerReady  = (state == READER_IDLE);
  // Issue stalls once two bytes are queued: the one read in flight plus the
  // push it may complete still fit in the FIFO.
  assign readEnable   = (state == READER_READ) && (fifoCount < CNT_W'(2));
  assign atLastCol    = (xAddr == ADDR_W'(OUT_WIDTH - 1));
  assign atLastRow    = (yAddr == ADDR_W'(OUT_HEIGHT - 1));
  assign lastIssue    = readEnable && atLastCol && atLastRow;
  assign xReadAddress = xAddr;
  assign yReadAddress = yAddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= READER_IDLE;
      xAddr <= '0;
      yAddr <= '0;
    end else begin
      case (state)
        READER_IDLE: if (start) begin
          state <= READER_READ;
          xAddr <= '0;
          yAddr <= '0;
        end
        READER_READ: if (readEnable) begin
          if (atLastCol) begin
            xAddr <= '0;
            if (atLastRow) state <= READER_DRAIN;
            else           yAddr <= yAddr + ADDR_W'(1);
          end else begin
            xAddr <= xAddr + ADDR_W'(1);
          end
        end
        READER_DRAIN: if (popByte && lastByte) state <= READER_IDLE;
        default: state <= READER_IDLE;
      endcase
    end
  end

  // ---- stage p1: RAM data returns, bits packed into the assembly register ----
  assign packedByte = insertBit(packReg_p1, readData, bitIdx_p1);
  assign pushByte   = readVld_p1 && ((bitIdx_p1 == 3'd7) || lastPix_p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readVld_p1 <= 1'b0;
      lastPix_p1 <= 1'b0;
      packReg_p1 <= '0;
      bitIdx_p1  <= '0;
    end else begin
      readVld_p1 <= readEnable;
      lastPix_p1 <= lastIssue;
      if (readVld_p1) begin
        if (pushByte) begin
          packReg_p1 <= '0;
          bitIdx_p1  <= '0;
        end else begin
          packReg_p1 <= packedByte;
          bitIdx_p1  <= bitIdx_p1 + 3'd1;
        end
      end
    end
  end

  // ---- stage p2: byte FIFO toward the downstream link ----
  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushByte),
    .pushData ({lastPix_p1, packedByte}),
    .pop      (popByte),
    .headData (fifoHead),
    .count    (fifoCount)
  );

  assign byteValid = (fifoCount != '0);
  assign byteOut   = byteValid ? fifoHead[7:0] : 8'h00;
  assign lastByte  = byteValid && fifoHead[8];
  assign popByte   = byteValid && byteReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) readerDone <= 1'b0;
    else        readerDone <= popByte && lastByte;
  end

endmodule

// File: doc/filtered_frame_reader.md
# filtered_frame_reader

Reads the binary median-filtered frame back out of the output frame RAM after filtering completes. Scans the 238×178 valid output region in row-major order and packs 8 pixels per byte. Streams the bytes to the downstream link (host/UART framer) over a valid/ready handshake. It is the read-side counterpart of the median write path: the filter writes the buffer, this block drains it.

## Interface
Parameters:
- OUT_WIDTH, 238, valid filtered columns (IMAGE_WIDTH − WINDOW_SIZE + 1)
- OUT_HEIGHT, 178, valid filtered rows (IMAGE_HEIGHT − WINDOW_SIZE + 1)
- ADDR_W, 8, width of x/y read addresses
- FIFO_DEPTH, 4, output byte FIFO entries

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin readout; sampled only in IDLE
- readerReady  out  1  high in IDLE
- xReadAddress  out  ADDR_W  column of pixel being read
- yReadAddress  out  ADDR_W  row of pixel being read
- readEnable  out  1  read strobe to output RAM
- readData  in  1  pixel value, valid exactly one cycle after readEnable
- byteOut  out  8  packed pixels, LSB = earliest pixel
- byteValid  out  1  byteOut holds a valid byte
- byteReady  in  1  downstream accepts byte when byteValid && byteReady
- lastByte  out  1  qualifies byteOut as final byte of frame
- readerDone  out  1  one-cycle pulse on final byte handshake

## Operation
- States: IDLE, READ, DRAIN.
- IDLE → READ on start. READ → DRAIN on the cycle readEnable is issued for (OUT_WIDTH−1, OUT_HEIGHT−1). DRAIN → IDLE on the lastByte handshake.
- Address scan: x = 0..OUT_WIDTH−1, then x wraps to 0 and y increments. Both counters restart at (0,0) on every IDLE → READ transition.
- Addresses advance only on cycles with readEnable high.
- readEnable = (state == READ) && (fifoCount < 2). This stalls issue on backpressure. At most one read is in flight, and at most one push can follow a stall, so the FIFO never overflows. An overflow is a design error and the bench asserts against it.
- Packing: the returned readData bit goes to bit position bitIdx of the assembly register, then bitIdx increments (3-bit).
- On the 8th bit, or on the frame's final pixel, {last, byte} is pushed into the FIFO and the assembly register clears.
- Total pixels = 42364 = 5295×8 + 4. The frame yields 5296 bytes. The final byte carries 4 pixels in bits 3:0, with bits 7:4 = 0.
- Packing runs continuously across row boundaries; there is no per-row padding.
- FIFO head drives byteOut and lastByte. Both hold stable while byteValid && !byteReady.
- start during READ or DRAIN is ignored.
- Reset while in READ or DRAIN behaves as a reset at any other time: state, counters, assembly register and FIFO clear immediately, and a partial byte is discarded.

## Timing
- Reset values: readerReady=1; readEnable=0; x/yReadAddress=0; byteOut=0; byteValid=0; lastByte=0; readerDone=0.
- start high in IDLE at cycle T → READ at T+1, first readEnable at T+1 with address (0,0).
- With byteReady=1: pixels read one per cycle. The first byte is pushed at the end of T+9, and byteValid is first high at T+10.
- The FIFO push and pop of a full FIFO in the same cycle are both honoured; count is unchanged.
- A push into an empty FIFO makes byteValid high the next cycle.
- readerDone is high the cycle after the lastByte handshake, coincident with the return to IDLE and readerReady=1.
- Throughput: one byte per 8 cycles when unthrottled.

## Structure
- Shared package filter_pkg: IMAGE_WIDTH, IMAGE_HEIGHT, WINDOW_SIZE, derived OUT_WIDTH/OUT_HEIGHT, reader state encoding.
- Sub-module byte_fifo: 4×9 bits (data + last flag), with count output, simultaneous push/pop, and async active-low reset.

## Test plan
- Reset: assert reset mid-idle → all outputs at reset values immediately; readerReady=1 after release.
- Alternating pattern RAM with pixel = (x+y)&1, byteReady=1:
  - first byteValid at T+10 with byteOut=0xAA;
  - byte index 29 (row-crossing, pixels (232..237,0),(0..1,1)) = 0x6A;
  - 5296 bytes total.
- All-ones RAM: bytes 0..5294 = 0xFF; final byte 0x0F with lastByte=1; readerDone pulses once; readerReady returns high.
- Backpressure: hold byteReady=0 for 50 cycles after the first byteValid →
  - readEnable drops within 2 cycles;
  - byteOut stable throughout;
  - FIFO count ≤ 4;
  - no byte lost or duplicated against the reference model.
- start pulsed during READ → ignored; scan continues without address restart.
- Reset asserted after byte 100 handshake, then restarted → first read at (0,0), and the full 5296-byte frame matches the model.
